rptr_handler: RTL and testbench

Read-side pointer and status block of the asynchronous FIFO; counterpart to the write-pointer handler in the write domain. It owns the binary and Gray read pointers and produces the empty flag. It also produces an almost-empty flag, a read-side fill count and a sticky underflow flag. The block runs entirely in the read clock domain. It consumes the write Gray pointer after the 2-flop synchronizer and exports its Gray read pointer to the write domain's synchronizer.

---
 rtl/fifo_pkg.sv | 21 ++
 rtl/rptr_handler_gray2bin.sv | 13 +
 rtl/rptr_handler.sv | 68 ++++++
 tb/tb_rptr_handler.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and Gray-code helpers for both pointer handlers of the asynchronous FIFO.
package fifo_pkg;

  localparam int FIFO_PTR_WIDTH = 3;
  localparam int DEPTH          = 2 ** FIFO_PTR_WIDTH;

  // Helpers work on a 32-bit container; callers zero-extend and truncate to their pointer width.
  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] gray);
    logic [31:0] bin;
    bin = gray;
    for (int s = 1; s < 32; s = s * 2) begin
      bin = bin ^ (bin >> s);
    end
    return bin;
  endfunction

endpackage

// File: rtl/rptr_handler_gray2bin.sv
// Combinational Gray-to-binary converter; each binary bit is the XOR of all Gray bits at or above it.
module gray2bin #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign bin[i] = ^gray[WIDTH-1:i];
  end

endmodule

// File: rtl/rptr_handler.sv
// Read-side pointer/status block of the asynchronous FIFO: binary and Gray read pointers,
// empty / almost-empty flags, conservative fill count and a sticky underflow flag, all in rclk.
module rptr_handler
  import fifo_pkg::*;
#(
  parameter int PTR_WIDTH = FIFO_PTR_WIDTH,
  parameter int AE_THRESH = 1
) (
  input  logic                 rclk,
  input  logic                 rrst,
  input  logic                 r_en,
  input  logic [PTR_WIDTH:0]   g_wptr_sync,
  input  logic                 underflow_clr,
  output logic [PTR_WIDTH:0]   b_rptr,
  output logic [PTR_WIDTH:0]   g_rptr,
  output logic                 empty,
  output logic                 almost_empty,
  output logic [PTR_WIDTH:0]   rd_count,
  output logic                 underflow
);

  localparam int PW = PTR_WIDTH + 1;

  logic          rd_accept;
  logic [PW-1:0] b_wptr_conv;
  logic [PW-1:0] b_rptr_next;
  logic [PW-1:0] g_rptr_next;
  logic [PW-1:0] rd_count_next;
  logic          empty_next;
  logic          almost_empty_next;

  gray2bin #(.WIDTH(PW)) u_wptr_g2b (
    .gray (g_wptr_sync),
    .bin  (b_wptr_conv)
  );

  // The registered empty gates reads, so a read never races the flag it depends on.
  assign rd_accept         = r_en && !empty;
  assign b_rptr_next       = b_rptr + PW'(rd_accept);
  assign g_rptr_next       = PW'(bin2gray(32'(b_rptr_next)));
  assign empty_next        = (g_rptr_next == g_wptr_sync);
  assign rd_count_next     = b_wptr_conv - b_rptr_next;
  assign almost_empty_next = (32'(rd_count_next) <= 32'(AE_THRESH));

  always_ff @(posedge rclk) begin
    if (rrst) begin
      b_rptr       <= '0;
      g_rptr       <= '0;
      empty        <= 1'b1;
      almost_empty <= 1'b1;
      rd_count     <= '0;
      underflow    <= 1'b0;
    end else begin
      b_rptr       <= b_rptr_next;
      g_rptr       <= g_rptr_next;
      empty        <= empty_next;
      almost_empty <= almost_empty_next;
      rd_count     <= rd_count_next;
      // Set has priority over clear when both happen on the same edge.
      if (r_en && empty) begin
        underflow <= 1'b1;
      end else if (underflow_clr) begin
        underflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rptr_handler.sv
// Bench for rptr_handler: directed plan steps followed by randomized traffic, checked against
// an integer occupancy model of the FIFO read side.
module tb_rptr_handler;
  import fifo_pkg::*;

  localparam int PW  = FIFO_PTR_WIDTH + 1;
  localparam int MOD = 2 * DEPTH;

  logic          rclk = 1'b0;
  logic          rrst;
  logic          r_en;
  logic [PW-1:0] g_wptr_sync;
  logic          underflow_clr;
  logic [PW-1:0] b_rptr;
  logic [PW-1:0] g_rptr;
  logic          empty;
  logic          almost_empty;
  logic [PW-1:0] rd_count;
  logic          underflow;

  int tests_run = 0;
  int tests_failed = 0;

  // model state: write/read positions as plain integers modulo 2*DEPTH
  int   m_wr = 0;
  int   m_rd = 0;
  int   m_cnt = 0;
  logic m_empty = 1'b1;
  logic m_uf = 1'b0;

  logic [14:0] exp_q[$];

  rptr_handler #(.PTR_WIDTH(FIFO_PTR_WIDTH), .AE_THRESH(1)) dut (
    .rclk          (rclk),
    .rrst          (rrst),
    .r_en          (r_en),
    .g_wptr_sync   (g_wptr_sync),
    .underflow_clr (underflow_clr),
    .b_rptr        (b_rptr),
    .g_rptr        (g_rptr),
    .empty         (empty),
    .almost_empty  (almost_empty),
    .rd_count      (rd_count),
    .underflow     (underflow)
  );

  always #5 rclk = ~rclk;

  function automatic logic [PW-1:0] to_gray(input int v);
    return PW'(v ^ (v >> 1));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance the model on the edge, compare #1 later.
  task automatic step(input logic rst, input logic ren, input logic clr);
    logic [14:0] e;
    rrst = rst;
    r_en = ren;
    underflow_clr = clr;
    g_wptr_sync = to_gray(m_wr);
    @(posedge rclk);
    if (rst) begin
      m_rd = 0;
      m_cnt = 0;
      m_empty = 1'b1;
      m_uf = 1'b0;
    end else begin
      if (ren && m_empty) m_uf = 1'b1;
      else if (clr) m_uf = 1'b0;
      if (ren && !m_empty) m_rd = (m_rd + 1) % MOD;
      m_cnt = (m_wr - m_rd + MOD) % MOD;
      m_empty = (m_cnt == 0);
    end
    exp_q.push_back({PW'(m_rd), to_gray(m_rd), m_empty, (m_cnt <= 1), PW'(m_cnt), m_uf});
    #1;
    e = exp_q.pop_front();
    chk("b_rptr", 32'(b_rptr), 32'(e[14:11]));
    chk("g_rptr", 32'(g_rptr), 32'(e[10:7]));
    chk("empty", 32'(empty), 32'(e[6]));
    chk("almost_empty", 32'(almost_empty), 32'(e[5]));
    chk("rd_count", 32'(rd_count), 32'(e[4:1]));
    chk("underflow", 32'(underflow), 32'(e[0]));
  endtask

  initial begin
    logic [PW-1:0] g_tab [4];
    g_tab[0] = 4'b0001; g_tab[1] = 4'b0011; g_tab[2] = 4'b0010; g_tab[3] = 4'b0110;
    rrst = 1'b1; r_en = 1'b0; underflow_clr = 1'b0; g_wptr_sync = '0;

    // 1. reset
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_ae", 32'(almost_empty), 32'd1);
    chk("rst_count", 32'(rd_count), 32'd0);

    // 2. fill to 4, drain to empty
    m_wr = 4;
    step(1'b0, 1'b0, 1'b0);
    chk("fill_count", 32'(rd_count), 32'd4);
    chk("fill_empty", 32'(empty), 32'd0);
    chk("fill_ae", 32'(almost_empty), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 1'b0);
      chk("drain_b", 32'(b_rptr), 32'(i + 1));
      chk("drain_g", 32'(g_rptr), 32'(g_tab[i]));
      chk("drain_count", 32'(rd_count), 32'(3 - i));
      chk("drain_ae", 32'(almost_empty), 32'(i >= 2));
      chk("drain_empty", 32'(empty), 32'(i == 3));
    end

    // 3. underflow, set-wins, clear
    step(1'b0, 1'b1, 1'b0);
    chk("uf_set", 32'(underflow), 32'd1);
    chk("uf_hold_ptr", 32'(b_rptr), 32'd4);
    step(1'b0, 1'b1, 1'b1);
    chk("uf_set_wins", 32'(underflow), 32'd1);
    step(1'b0, 1'b0, 1'b1);
    chk("uf_clr", 32'(underflow), 32'd0);

    // 4. wrap-around: reach full distance, then read while writer keeps pace
    for (int i = 0; i < 8; i++) begin
      m_wr = (m_wr + 1) % MOD;
      step(1'b0, 1'b0, 1'b0);
    end
    chk("full_count", 32'(rd_count), 32'd8);
    chk("full_not_empty", 32'(empty), 32'd0);
    for (int i = 0; i < 30; i++) begin
      m_wr = (m_wr + 1) % MOD;
      step(1'b0, 1'b1, 1'b0);
    end
    while (m_cnt != 0) step(1'b0, 1'b1, 1'b0);
    chk("wrap_drained", 32'(empty), 32'd1);

    // 5. read and write on the same edge with one word present
    m_wr = (m_wr + 1) % MOD;
    step(1'b0, 1'b0, 1'b0);
    m_wr = (m_wr + 1) % MOD;
    step(1'b0, 1'b1, 1'b0);
    chk("simul_count", 32'(rd_count), 32'd1);
    chk("simul_empty", 32'(empty), 32'd0);

    // 6. reset mid-drain, both domains restart together
    m_wr = (m_wr + 2) % MOD;
    step(1'b0, 1'b0, 1'b0);
    chk("pre_rst_count", 32'(rd_count), 32'd3);
    m_wr = 0;
    step(1'b1, 1'b1, 1'b0);
    chk("mid_rst_b", 32'(b_rptr), 32'd0);
    chk("mid_rst_empty", 32'(empty), 32'd1);
    m_wr = 2;
    step(1'b0, 1'b0, 1'b0);
    chk("post_rst_count", 32'(rd_count), 32'd2);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic do_rst;
      do_rst = ($urandom_range(0, 99) == 0);
      if (do_rst) m_wr = 0;
      else if ($urandom_range(0, 1) == 1 && ((m_wr - m_rd + MOD) % MOD) < DEPTH)
        m_wr = (m_wr + 1) % MOD;
      step(do_rst, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
